// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Default build retires one multiplier bit per cycle (latency WIDTH).
// Define MULT_RADIX4_EN to retire two bits per cycle (latency WIDTH/2);
// WIDTH must be even in that mode. Results and handshake are identical.
module multiplier #(
   parameter int WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic [2*WIDTH-1:0]   p,
   output logic                 out_en
);

`ifdef MULT_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int ITER  = WIDTH / STEP;       // iterations per product
   localparam int SW    = WIDTH + STEP;       // adder width, keeps the carry bits
   localparam int CNT_W = $clog2(ITER + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 out_en_q, out_en_d;
`ifdef MULT_RADIX4_EN
   logic [SW-1:0]        mcand3_q, mcand3_d;  // 3x multiplicand, built once at start
`endif

   logic [SW-1:0]        addend_s;
   logic [SW-1:0]        sum_s;

   // Partial product for the low multiplier digit, added into the upper half
   always_comb begin
      addend_s = '0;
`ifdef MULT_RADIX4_EN
      case (mplr_q[1:0])
         2'd0:    addend_s = '0;
         2'd1:    addend_s = {2'b00, mcand_q};
         2'd2:    addend_s = {1'b0, mcand_q, 1'b0};
         default: addend_s = mcand3_q;
      endcase
`else
      if (mplr_q[0]) begin
         addend_s = {1'b0, mcand_q};
      end
`endif
      sum_s = {{STEP{1'b0}}, acc_q} + addend_s;
   end

   // Next-state and datapath control for the IDLE/BUSY sequencer
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      out_en_d = 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3_d = mcand3_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = x;
               mplr_d  = y;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MULT_RADIX4_EN
               mcand3_d = {2'b00, x} + {1'b0, x, 1'b0};
`endif
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Shift {sum, mplr} right by STEP: low sum bits move into mplr's top
            acc_d  = sum_s[SW-1:STEP];
            mplr_d = {sum_s[STEP-1:0], mplr_q[WIDTH-1:STEP]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
               p_d      = {sum_s, mplr_q[WIDTH-1:STEP]};
               out_en_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         out_en_q <= 1'b0;
`ifdef MULT_RADIX4_EN
         mcand3_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         out_en_q <= out_en_d;
`ifdef MULT_RADIX4_EN
         mcand3_q <= mcand3_d;
`endif
      end
   end

   assign p      = p_q;
   assign out_en = out_en_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: the driver pushes expected product and
// due cycle; the monitor pops on each out_en pulse and checks value and timing.
// Also checks reset state and that p holds between pulses.
// Build with MULT_RADIX4_EN defined to exercise the two-bits-per-cycle mode.
module tb_multiplier;
   localparam int W = 24;
`ifdef MULT_RADIX4_EN
   localparam int LAT = W / 2;
`else
   localparam int LAT = W;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [W-1:0]    x = '0;
   logic [W-1:0]    y = '0;
   logic [2*W-1:0]  p;
   logic            out_en;

   typedef struct {
      logic [2*W-1:0] prod;
      int             due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   multiplier #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .x      (x),
      .y      (y),
      .p      (p),
      .out_en (out_en)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sampled 1 time unit after each rising edge
   initial begin
      logic [2*W-1:0] hold_p;
      exp_t           e;
      hold_p = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            exp_q.delete();
            hold_p = '0;
            checks++;
            if (p !== '0 || out_en !== 1'b0) begin
               errors++;
               $display("FAIL reset_state: p=%h out_en=%b required p=0 out_en=0", p, out_en);
            end
         end else if (out_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out_en: p=%h at cycle %0d, no operation pending", p, cyc);
            end else begin
               e = exp_q.pop_front();
               if (p !== e.prod || cyc != e.due) begin
                  errors++;
                  $display("FAIL product: p=%h at cycle %0d required p=%h at cycle %0d",
                           p, cyc, e.prod, e.due);
               end else begin
                  $display("result p=%h at cycle %0d ok", p, cyc);
               end
               hold_p = e.prod;
            end
         end else begin
            checks++;
            if (out_en !== 1'b0 || p !== hold_p) begin
               errors++;
               $display("FAIL p_hold: p=%h out_en=%b required p=%h out_en=0", p, out_en, hold_p);
            end
         end
      end
   end

   // Wait until every pushed expectation has been consumed
   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * LAT + 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results still pending after %0d cycles", exp_q.size(), n);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Single-cycle start pulse; the next rising edge samples it
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] prod);
      exp_t e;
      @(negedge clk);
      x = a;
      y = b;
      start = 1'b1;
      e.prod = prod;
      e.due  = cyc + 1 + LAT;
      exp_q.push_back(e);
      $display("issue x=%h y=%h expect p=%h", a, b, prod);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   base;

      // Reset two cycles, then idle with start low
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Directed products
      issue(24'h81FF20, 24'h800E00, 48'h4106ABF3C000);
      wait_idle();
      issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      wait_idle();
      issue(24'h000001, 24'hABCDEF, 48'h000000ABCDEF);
      wait_idle();
      issue(24'h000000, 24'h123456, 48'h000000000000);
      wait_idle();
      issue(24'hABCDEF, 24'h000000, 48'h000000000000);
      wait_idle();
      issue(24'hFFFFFF, 24'h000003, 48'h000002FFFFFD);
      wait_idle();
      issue(24'h000002, 24'h800000, 48'h000001000000);
      wait_idle();

      // Start held high, operands changed mid-operation
      @(negedge clk);
      base  = cyc;
      x     = 24'h000003;
      y     = 24'h000005;
      start = 1'b1;
      e.prod = 48'h00000000000F;
      e.due  = base + 1 + LAT;
      exp_q.push_back(e);
      $display("issue held x=000003 y=000005 expect p=%h", e.prod);
      repeat (3) @(negedge clk);
      x = 24'h001000;
      y = 24'h000100;
      e.prod = 48'h000000100000;
      e.due  = base + 1 + 2 * LAT + 1;
      exp_q.push_back(e);
      $display("issue held x=001000 y=000100 expect p=%h", e.prod);
      while (cyc < base + LAT + 2) @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset ten cycles into an operation aborts it
      @(negedge clk);
      x = 24'h81FF20;
      y = 24'h800E00;
      start = 1'b1;
      e.prod = 48'h4106ABF3C000;
      e.due  = cyc + 1 + LAT;
      exp_q.push_back(e);
      $display("issue x=81ff20 y=800e00 to be aborted by reset");
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * LAT) @(negedge clk);

      // Fresh operation after the abort
      issue(24'h123456, 24'h000010, 48'h000001234560);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
